// File: rtl/regfile_param.sv
// Parametrised register file with two combinational read ports and a handshaked dump sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_en,
    input  logic            dump_start,
    output logic            dump_busy,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic          ZR       = (ZERO_REG != 0);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0] r_regs [NREGS];
    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_dump_idx;
    logic [AW-1:0]   w_dump_idx_nxt;
    logic            w_wr_commit;
    logic            w_rs1_zero;
    logic            w_rs2_zero;

    // x0 writes are dropped so register 0 stays at its reset value of zero
    assign w_wr_commit = wr_en && !(ZR && (rd_addr == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[rd_addr] <= wr_data;
        end
    end

    assign w_rs1_zero = ZR && (rs1_addr == '0);
    assign w_rs2_zero = ZR && (rs2_addr == '0);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        rs2_data = r_regs[rs2_addr];
        if (wr_en && (rd_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
        if (wr_en && (rd_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
        if (w_rs1_zero) begin
            rs1_data = '0;
        end
        if (w_rs2_zero) begin
            rs2_data = '0;
        end
    end
`else
    always_comb begin
        rs1_data = w_rs1_zero ? '0 : r_regs[rs1_addr];
        rs2_data = w_rs2_zero ? '0 : r_regs[rs2_addr];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dump_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dump_idx <= w_dump_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dump_idx_nxt = r_dump_idx;
        dump_valid     = 1'b0;
        dump_busy      = 1'b0;
        dump_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dump_start) begin
                    w_dump_idx_nxt = '0;
                    w_state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (r_dump_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_dump_idx_nxt = r_dump_idx + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                dump_done      = 1'b1;
                w_dump_idx_nxt = '0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_dump_idx_nxt = '0;
            end
        endcase
    end

    // Dump reads the live array so committed writes show up while a word is stalled
    assign dump_idx  = r_dump_idx;
    assign dump_data = r_regs[r_dump_idx];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed test-plan steps plus randomized traffic
// compared against an array-based reference model (both ZERO_REG settings instantiated).
module tb_regfile_param;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clock;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] wr_data;
    logic            wr_en, dump_start, dump_ready;
    logic [XLEN-1:0] rs1_data, rs2_data, dump_data;
    logic            dump_busy, dump_valid, dump_done;
    logic [AW-1:0]   dump_idx;

    logic [XLEN-1:0] nz_rs1_data, nz_rs2_data, nz_dump_data;
    logic            nz_dump_busy, nz_dump_valid, nz_dump_done;
    logic [AW-1:0]   nz_dump_idx;

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) u_dut (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_addr(rd_addr), .wr_data(wr_data), .wr_en(wr_en),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0)) u_dut_nz (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nz_rs1_data), .rs2_data(nz_rs2_data),
        .rd_addr(rd_addr), .wr_data(wr_data), .wr_en(wr_en),
        .dump_start(dump_start), .dump_busy(nz_dump_busy), .dump_valid(nz_dump_valid),
        .dump_ready(dump_ready), .dump_idx(nz_dump_idx), .dump_data(nz_dump_data),
        .dump_done(nz_dump_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: register arrays plus the dump position as plain integers
    logic [XLEN-1:0] mdl    [NREGS];
    logic [XLEN-1:0] mdl_nz [NREGS];
    bit              m_active;
    bit              m_done;
    int              m_idx;
    int              acc_cnt;
    int              done_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input bit zr, input int a);
        if (zr && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(rd_addr) == a) return wr_data;
`endif
        return zr ? mdl[a] : mdl_nz[a];
    endfunction

    task automatic check_all();
        chk("rs1_data", 64'(rs1_data), 64'(exp_read(1'b1, int'(rs1_addr))));
        chk("rs2_data", 64'(rs2_data), 64'(exp_read(1'b1, int'(rs2_addr))));
        chk("nz_rs1_data", 64'(nz_rs1_data), 64'(exp_read(1'b0, int'(rs1_addr))));
        chk("nz_rs2_data", 64'(nz_rs2_data), 64'(exp_read(1'b0, int'(rs2_addr))));
        chk("dump_valid", 64'(dump_valid), 64'(m_active));
        chk("dump_busy", 64'(dump_busy), 64'(m_active));
        chk("dump_done", 64'(dump_done), 64'(m_done));
        chk("nz_dump_valid", 64'(nz_dump_valid), 64'(m_active));
        if (!m_done) chk("dump_idx", 64'(dump_idx), 64'(m_idx));
        if (m_active) begin
            chk("dump_data", 64'(dump_data), 64'(mdl[m_idx]));
            chk("nz_dump_data", 64'(nz_dump_data), 64'(mdl_nz[m_idx]));
        end
        if (dump_valid && dump_ready) acc_cnt++;
        if (dump_done) done_cnt++;
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mdl[i] = '0;
                mdl_nz[i] = '0;
            end
            m_active = 0;
            m_done   = 0;
            m_idx    = 0;
        end else begin
            if (wr_en) begin
                if (rd_addr != 0) mdl[rd_addr] = wr_data;
                mdl_nz[rd_addr] = wr_data;
            end
            if (m_done) begin
                m_done = 0;
                m_idx  = 0;
            end else if (m_active) begin
                if (dump_ready) begin
                    if (m_idx == NREGS - 1) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (dump_start) begin
                m_active = 1;
                m_idx    = 0;
            end
        end
    endtask

    // Check combinational outputs mid-cycle, then advance the model across the edge
    task automatic step();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; wr_en = 0; dump_start = 0; dump_ready = 0;
        rd_addr = '0; wr_data = '0; rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d);
        wr_en = 1; rd_addr = AW'(a); wr_data = d;
        step();
        wr_en = 0;
    endtask

    bit wrote;
    bit seen_done;
    int k;

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            mdl[i] = 'x;
            mdl_nz[i] = 'x;
        end
        m_active = 0; m_done = 0; m_idx = 0;
        acc_cnt = 0; done_cnt = 0;
        idle_inputs();
        reset = 1;
        @(posedge clock);
        model_edge();
        #1;
        reset = 0;

        // Reset state: every register reads zero on both instances
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(NREGS - 1 - a);
            step();
        end

        // Basic write/read
        wr(5, 32'hDEADBEEF);
        wr(31, 32'h00000007);
        rs1_addr = 5; rs2_addr = 31;
        step();
        chk("tp_rd5", 64'(rs1_data), 64'h00000000DEADBEEF);
        chk("tp_rd31", 64'(rs2_data), 64'h7);

        // x0 write: discarded on ZERO_REG=1, kept on ZERO_REG=0
        wr(0, 32'hFFFFFFFF);
        rs1_addr = 0;
        step();
        chk("tp_x0", 64'(rs1_data), 64'h0);
        chk("tp_x0_nz", 64'(nz_rs1_data), 64'hFFFFFFFF);

        // Same-cycle read/write hazard
        wr(3, 32'd10);
        rs1_addr = 3; wr_en = 1; rd_addr = 3; wr_data = 32'd20;
        @(negedge clock);
`ifdef REGFILE_BYPASS_EN
        chk("tp_hazard_same", 64'(rs1_data), 64'd20);
`else
        chk("tp_hazard_same", 64'(rs1_data), 64'd10);
`endif
        @(posedge clock); model_edge(); #1;
        wr_en = 0;
        step();
        chk("tp_hazard_next", 64'(rs1_data), 64'd20);

        // Full dump with ready held high
        for (int i = 0; i < NREGS; i++) wr(i, XLEN'(i * 4));
        acc_cnt = 0; done_cnt = 0; seen_done = 0;
        dump_ready = 1; dump_start = 1;
        step();
        dump_start = 0;
        for (k = 0; k < 3 * NREGS && !seen_done; k++) begin
            step();
            if (m_done) seen_done = 1;
        end
        chk("full_done_seen", 64'(seen_done), 64'd1);
        chk("full_steps", 64'(k), 64'(NREGS));
        step();
        step();
        chk("full_accepted", 64'(acc_cnt), 64'(NREGS));
        chk("full_done_cnt", 64'(done_cnt), 64'd1);
        chk("full_busy_after", 64'(dump_busy), 64'd0);

        // Backpressure with a live write to a stalled word and an ignored re-start
        acc_cnt = 0; done_cnt = 0; seen_done = 0; wrote = 0;
        dump_ready = 0; dump_start = 1;
        step();
        dump_start = 0;
        for (k = 0; k < 6 * NREGS && !seen_done; k++) begin
            dump_ready = (k % 3 == 0);
            dump_start = (k == 7);
            if (m_active && m_idx == 2 && !dump_ready && !wrote) begin
                wr_en = 1; rd_addr = 2; wr_data = 32'd99; wrote = 1;
            end else begin
                wr_en = 0;
            end
            if (m_active && m_idx == 2 && dump_ready)
                chk("bp_word2", 64'(dump_data), 64'd99);
            step();
            if (m_done) seen_done = 1;
        end
        wr_en = 0; dump_start = 0;
        step();
        chk("bp_done_seen", 64'(seen_done), 64'd1);
        chk("bp_wrote", 64'(wrote), 64'd1);
        chk("bp_accepted", 64'(acc_cnt), 64'(NREGS));
        chk("bp_done_cnt", 64'(done_cnt), 64'd1);

        // Reset in the middle of a dump
        done_cnt = 0;
        dump_ready = 1; dump_start = 1;
        step();
        dump_start = 0;
        for (k = 0; k < 4 * NREGS && m_idx != 10; k++) step();
        chk("rst_reached_10", 64'(dump_idx), 64'd10);
        reset = 1;
        step();
        reset = 0;
        @(negedge clock);
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_busy", 64'(dump_busy), 64'd0);
        chk("rst_idx", 64'(dump_idx), 64'd0);
        dump_ready = 0;
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(a);
            step();
        end
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        dump_start = 1;
        step();
        dump_start = 0;
        step();
        chk("restart_idx", 64'(dump_idx), 64'd0);
        chk("restart_valid", 64'(dump_valid), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            rs1_addr   = AW'($urandom);
            rs2_addr   = AW'($urandom);
            rd_addr    = ($urandom_range(0, 3) == 0) ? rs1_addr : AW'($urandom);
            wr_data    = $urandom;
            wr_en      = $urandom_range(0, 1);
            dump_ready = ($urandom_range(0, 2) != 0);
            dump_start = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
